// File: rtl/oled_frame_buffer_if.sv
// rtl/oled_frame_buffer_if.sv - pixel write port and frame byte stream bundle
//
// Groups the two handshake buses of the frame buffer:
//   pix_valid/pix_ready/pix_x/pix_y/pix_val    pixel read-modify-write requests
//   byte_data/byte_valid/byte_ready/byte_last  frame byte stream toward the SPI serializer
//   frame_done                                 one-cycle end-of-frame pulse
// slave  : the frame buffer side
// master : the game logic / serializer side
interface oled_frame_buffer_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [6:0] pix_x;
  logic [5:0] pix_y;
  logic       pix_val;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_last;
  logic       frame_done;

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_val, byte_ready,
    output pix_ready, byte_data, byte_valid, byte_last, frame_done
  );

  modport master (
    output pix_valid, pix_x, pix_y, pix_val, byte_ready,
    input  pix_ready, byte_data, byte_valid, byte_last, frame_done
  );
endinterface

// File: rtl/oled_frame_buffer.sv
// rtl/oled_frame_buffer.sv - 128x64 page-organised monochrome frame buffer with byte streamer
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   bus          oled_frame_buffer_if.slave: pixel RMW port and frame byte stream
//   clr_start    one-cycle request to fill the whole buffer with CLEAR_BYTE
//   frame_start  one-cycle request to stream the 1024-byte frame
//   busy         writer or streamer not idle
//
// Byte index = page*128 + column; bit n of a byte is row page*8+n (LSB = top row).
// The writer owns the RAM write port and its own read port; the streamer has a
// second read port, so pixel writes and streaming run concurrently.
module oled_frame_buffer #(
  parameter logic [7:0] CLEAR_BYTE = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  oled_frame_buffer_if.slave   bus,
  input  logic                 clr_start,
  input  logic                 frame_start,
  output logic                 busy
);

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_RMW   = 2'd1;
  localparam logic [1:0] W_CLEAR = 2'd2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [9:0] LAST_ADDR = 10'd1023;

  logic [7:0] mem [0:1023];

  logic [1:0] w_state;
  logic [9:0] w_addr;      // latched pixel address in W_RMW, running address in W_CLEAR
  logic [2:0] w_bit;
  logic       w_val;
  logic [7:0] w_rd_data;

  logic [1:0] s_state;
  logic [9:0] s_addr;
  logic [7:0] s_rd_data;
  logic [7:0] byte_data_q;
  logic       byte_valid_q;
  logic       frame_done_q;

  logic       pix_ready_c;
  logic       pix_accept;
  logic [9:0] pix_addr;
  logic [7:0] rmw_data;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic       s_handshake;
  logic       s_rd_en;
  logic [9:0] s_rd_addr;

  // clr_start has priority, so it masks pix_ready combinationally.
  assign pix_ready_c = (w_state == W_IDLE) && !clr_start;
  assign pix_accept  = bus.pix_valid && pix_ready_c;
  assign pix_addr    = {bus.pix_y[5:3], bus.pix_x};

  always_comb begin
    rmw_data        = w_rd_data;
    rmw_data[w_bit] = w_val;
  end

  assign mem_we    = (w_state == W_RMW) || (w_state == W_CLEAR);
  assign mem_wdata = (w_state == W_CLEAR) ? CLEAR_BYTE : rmw_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_addr  <= 10'd0;
      w_bit   <= 3'd0;
      w_val   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (clr_start) begin
            w_state <= W_CLEAR;
            w_addr  <= 10'd0;
          end else if (pix_accept) begin
            w_state <= W_RMW;
            w_addr  <= pix_addr;
            w_bit   <= bus.pix_y[2:0];
            w_val   <= bus.pix_val;
          end
        end
        W_RMW: w_state <= W_IDLE;
        W_CLEAR: begin
          w_addr <= w_addr + 10'd1;
          if (w_addr == LAST_ADDR) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Stream read address: 0 when a frame starts, otherwise the next byte.
  assign s_handshake = (s_state == S_HOLD) && bus.byte_ready;
  assign s_rd_en     = ((s_state == S_IDLE) && frame_start) ||
                       (s_handshake && (s_addr != LAST_ADDR));
  assign s_rd_addr   = (s_state == S_IDLE) ? 10'd0 : s_addr + 10'd1;

  // RAM is not reset. Nonblocking semantics give read-old-data when a write
  // and a read hit the same address on the same edge.
  always_ff @(posedge clk) begin
    if (mem_we) mem[w_addr] <= mem_wdata;
    if (pix_accept) w_rd_data <= mem[pix_addr];
    if (s_rd_en) s_rd_data <= mem[s_rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_state      <= S_IDLE;
      s_addr       <= 10'd0;
      byte_data_q  <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (s_state)
        S_IDLE: begin
          if (frame_start) begin
            s_addr  <= 10'd0;
            s_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          byte_data_q  <= s_rd_data;
          byte_valid_q <= 1'b1;
          s_state      <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.byte_ready) begin
            byte_valid_q <= 1'b0;
            if (s_addr == LAST_ADDR) begin
              s_state      <= S_IDLE;
              frame_done_q <= 1'b1;
            end else begin
              s_addr  <= s_addr + 10'd1;
              s_state <= S_FETCH;
            end
          end
        end
        default: s_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pix_ready  = pix_ready_c;
  assign bus.byte_data  = byte_data_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_last  = byte_valid_q && (s_addr == LAST_ADDR);
  assign bus.frame_done = frame_done_q;
  assign busy           = (w_state != W_IDLE) || (s_state != S_IDLE);

endmodule

// File: tb/tb_oled_frame_buffer.sv
// tb/tb_oled_frame_buffer.sv - self-checking bench for oled_frame_buffer against a pixel-array model
module tb_oled_frame_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_start = 1'b0;
  logic frame_start = 1'b0;
  logic busy;

  oled_frame_buffer_if bus();

  oled_frame_buffer dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .clr_start(clr_start),
    .frame_start(frame_start),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit         pix_m [0:127][0:63];
  logic [7:0] got_q [$];
  bit         last_q [$];
  int         done_cnt;
  int         done_n;
  int         first_valid_n;
  int         stall_err;

  function automatic logic [7:0] exp_byte(int idx);
    int page = idx / 128;
    int col = idx % 128;
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = pix_m[col][page * 8 + k];
    return b;
  endfunction

  function automatic int frame_mismatches();
    int m = 0;
    if (got_q.size() != 1024) return 1024;
    for (int i = 0; i < 1024; i++) if (got_q[i] !== exp_byte(i)) m++;
    return m;
  endfunction

  function automatic int last_mismatches();
    int m = 0;
    if (last_q.size() != 1024) return 1024;
    for (int i = 0; i < 1024; i++) if (last_q[i] !== (i == 1023)) m++;
    return m;
  endfunction

  function automatic logic [7:0] got_at(int idx);
    if (got_q.size() > idx) return got_q[idx];
    return 8'hxx;
  endfunction

  task automatic model_clear();
    for (int x = 0; x < 128; x++)
      for (int y = 0; y < 64; y++) pix_m[x][y] = 1'b0;
  endtask

  task automatic wait_idle();
    int bound = 0;
    @(negedge clk);
    while (busy && bound < 20000) begin
      @(negedge clk);
      bound++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout busy=%0b required=0", busy);
    end
  endtask

  task automatic write_pixel(input int x, input int y, input bit v);
    int bound = 0;
    @(negedge clk);
    bus.pix_x = x[6:0];
    bus.pix_y = y[5:0];
    bus.pix_val = v;
    bus.pix_valid = 1'b1;
    while (!bus.pix_ready && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    if (!bus.pix_ready) begin
      checks++;
      failures++;
      $display("FAIL write_pixel_timeout pix_ready=%0b required=1", bus.pix_ready);
    end
    @(negedge clk);
    bus.pix_valid = 1'b0;
    pix_m[x][y] = v;
  endtask

  // n counts negedges after the clr_start edge; busy drops after the 1024th write.
  task automatic do_clear(output int n);
    wait_idle();
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    n = 1;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    model_clear();
  endtask

  // n counts negedges after the frame_start edge F.
  task automatic stream_frame(input int ready_pct, input int inject_at);
    int n = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    got_q.delete();
    last_q.delete();
    done_cnt = 0;
    done_n = 0;
    first_valid_n = 0;
    stall_err = 0;
    wait_idle();
    frame_start = 1'b1;
    bus.byte_ready = ($urandom_range(99) < ready_pct);
    while (n < 20000) begin
      @(negedge clk);
      n++;
      frame_start = (n == inject_at);
      if (prev_stall && (!bus.byte_valid || bus.byte_data !== prev_data)) stall_err++;
      if (bus.byte_valid && first_valid_n == 0) first_valid_n = n;
      if (bus.frame_done) begin
        done_cnt++;
        if (done_n == 0) done_n = n;
      end
      if (done_n != 0 && n >= done_n + 4) break;
      bus.byte_ready = ($urandom_range(99) < ready_pct);
      if (bus.byte_valid && bus.byte_ready) begin
        got_q.push_back(bus.byte_data);
        last_q.push_back(bus.byte_last);
      end
      prev_stall = bus.byte_valid && !bus.byte_ready;
      prev_data = bus.byte_data;
    end
    frame_start = 1'b0;
    bus.byte_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.pix_ready !== 1'b1) begin failures++; $display("FAIL reset_pix_ready got=%0b exp=1", bus.pix_ready); end
    checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL reset_byte_valid got=%0b exp=0", bus.byte_valid); end
    checks++; if (bus.byte_last !== 1'b0) begin failures++; $display("FAIL reset_byte_last got=%0b exp=0", bus.byte_last); end
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%0b exp=0", bus.frame_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (bus.byte_data !== 8'h00) begin failures++; $display("FAIL reset_byte_data got=%h exp=00", bus.byte_data); end
  endtask

  task automatic test_clear_stream();
    int n;
    do_clear(n);
    checks++; if (n !== 1025) begin failures++; $display("FAIL clear_duration got=%0d exp=1025", n); end
    checks++; if (bus.pix_ready !== 1'b1) begin failures++; $display("FAIL clear_pix_ready_after got=%0b exp=1", bus.pix_ready); end
    stream_frame(100, 0);
    checks++; if (got_q.size() !== 1024) begin failures++; $display("FAIL clear_byte_count got=%0d exp=1024", got_q.size()); end
    checks++; if (frame_mismatches() !== 0) begin failures++; $display("FAIL clear_frame_data mismatches=%0d exp=0", frame_mismatches()); end
    checks++; if (last_mismatches() !== 0) begin failures++; $display("FAIL clear_byte_last mismatches=%0d exp=0", last_mismatches()); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL clear_done_count got=%0d exp=1", done_cnt); end
    checks++; if (done_n !== 2049) begin failures++; $display("FAIL clear_done_timing got=%0d exp=2049", done_n); end
    checks++; if (first_valid_n !== 2) begin failures++; $display("FAIL first_valid_timing got=%0d exp=2", first_valid_n); end
  endtask

  task automatic test_single_pixel();
    int n;
    do_clear(n);
    write_pixel(5, 10, 1'b1);
    stream_frame(100, 0);
    checks++; if (got_at(133) !== 8'h04) begin failures++; $display("FAIL single_byte133 got=%h exp=04", got_at(133)); end
    checks++; if (frame_mismatches() !== 0) begin failures++; $display("FAIL single_frame mismatches=%0d exp=0", frame_mismatches()); end
    do_clear(n);
    write_pixel(127, 63, 1'b1);
    stream_frame(100, 0);
    checks++; if (got_at(1023) !== 8'h80) begin failures++; $display("FAIL corner_byte1023 got=%h exp=80", got_at(1023)); end
    checks++; if (frame_mismatches() !== 0) begin failures++; $display("FAIL corner_frame mismatches=%0d exp=0", frame_mismatches()); end
  endtask

  task automatic test_rmw_sequence();
    int n;
    int req = 0;
    int rx [3] = '{5, 5, 5};
    int ry [3] = '{10, 11, 10};
    bit rv [3] = '{1'b1, 1'b1, 1'b0};
    logic [5:0] seq;
    do_clear(n);
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (req < 3) begin
        bus.pix_x = rx[req][6:0];
        bus.pix_y = ry[req][5:0];
        bus.pix_val = rv[req];
        bus.pix_valid = 1'b1;
      end else begin
        bus.pix_valid = 1'b0;
      end
      seq[5 - i] = bus.pix_ready;
      if (bus.pix_ready && bus.pix_valid) begin
        pix_m[rx[req]][ry[req]] = rv[req];
        req++;
      end
    end
    bus.pix_valid = 1'b0;
    checks++; if (seq !== 6'b101010) begin failures++; $display("FAIL rmw_ready_seq got=%b exp=101010", seq); end
    stream_frame(100, 0);
    checks++; if (got_at(133) !== 8'h08) begin failures++; $display("FAIL rmw_byte133 got=%h exp=08", got_at(133)); end
    checks++; if (frame_mismatches() !== 0) begin failures++; $display("FAIL rmw_frame mismatches=%0d exp=0", frame_mismatches()); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 60; i++)
      write_pixel($urandom_range(127), $urandom_range(63), ($urandom_range(3) != 0));
    stream_frame(30, 300);
    checks++; if (got_q.size() !== 1024) begin failures++; $display("FAIL bp_byte_count got=%0d exp=1024", got_q.size()); end
    checks++; if (frame_mismatches() !== 0) begin failures++; $display("FAIL bp_frame mismatches=%0d exp=0", frame_mismatches()); end
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL bp_stall_stability errors=%0d exp=0", stall_err); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
    checks++; if (last_mismatches() !== 0) begin failures++; $display("FAIL bp_byte_last mismatches=%0d exp=0", last_mismatches()); end
  endtask

  task automatic test_collisions();
    int bound = 0;
    wait_idle();
    clr_start = 1'b1;
    bus.pix_x = 7'd3;
    bus.pix_y = 6'd3;
    bus.pix_val = 1'b1;
    bus.pix_valid = 1'b1;
    #1;
    checks++; if (bus.pix_ready !== 1'b0) begin failures++; $display("FAIL clr_vs_pix_ready got=%0b exp=0", bus.pix_ready); end
    @(negedge clk);
    clr_start = 1'b0;
    checks++; if (bus.pix_ready !== 1'b0) begin failures++; $display("FAIL clr_wins_ready got=%0b exp=0", bus.pix_ready); end
    bus.pix_valid = 1'b0;
    while (busy && bound < 3000) begin
      @(negedge clk);
      bound++;
    end
    model_clear();
    stream_frame(100, 0);
    checks++; if (frame_mismatches() !== 0) begin failures++; $display("FAIL clr_wins_frame mismatches=%0d exp=0", frame_mismatches()); end

    wait_idle();
    bus.pix_x = 7'd9;
    bus.pix_y = 6'd20;
    bus.pix_val = 1'b1;
    bus.pix_valid = 1'b1;
    @(negedge clk);
    bus.pix_valid = 1'b0;
    pix_m[9][20] = 1'b1;
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_during_rmw_busy got=%0b exp=0", busy); end
    stream_frame(100, 0);
    checks++; if (got_at(265) !== 8'h10) begin failures++; $display("FAIL clr_during_rmw_byte265 got=%h exp=10", got_at(265)); end
    checks++; if (frame_mismatches() !== 0) begin failures++; $display("FAIL clr_during_rmw_frame mismatches=%0d exp=0", frame_mismatches()); end
  endtask

  task automatic test_async_reset();
    wait_idle();
    frame_start = 1'b1;
    bus.byte_ready = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    checks++; if (bus.byte_valid !== 1'b1) begin failures++; $display("FAIL areset_pre_valid got=%0b exp=1", bus.byte_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL areset_byte_valid got=%0b exp=0", bus.byte_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%0b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.pix_ready !== 1'b1) begin failures++; $display("FAIL areset_pix_ready got=%0b exp=1", bus.pix_ready); end
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_x = 7'd0;
    bus.pix_y = 6'd0;
    bus.pix_val = 1'b0;
    bus.byte_ready = 1'b0;
    model_clear();
    test_reset();
    test_clear_stream();
    test_single_pixel();
    test_rmw_sequence();
    test_backpressure();
    test_collisions();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout time=%0t limit=3000000", $time);
    $fatal(1, "timeout");
  end

endmodule
